// File: rtl/pool_bus_pkg.sv
// rtl/pool_bus_pkg.sv - shared types and constants for the pooling write-back path
package pool_bus_pkg;

   typedef enum logic [2:0] {
      ST_UNINIT,
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B
   } pwb_state_e;

   localparam int             BURST_BEATS = 16;
   localparam int             BEAT_BYTES  = 4;
   localparam int             BURST_BYTES = BURST_BEATS * BEAT_BYTES;
   localparam logic [3:0]     AWLEN       = 4'd15;
   localparam int             ADDR_W      = 28;
   localparam int             ID_W        = 4;

endpackage

// File: rtl/pool_wr_bridge.sv
// rtl/pool_wr_bridge.sv - single 16-beat burst engine over the AW/W/B channels
module pool_wr_bridge
   import pool_bus_pkg::*;
#(
   parameter int              WORD_W = 32,
   parameter logic [ID_W-1:0] WR_ID  = 4'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_ap,
   output logic [3:0]        beat_idx,
   input  logic [WORD_W-1:0] beat_data,
   output logic              done,
   output logic              PwbBus_awvalid,
   input  logic              BusPwb_awready,
   output logic [ADDR_W-1:0] PwbBus_awaddr,
   output logic [3:0]        PwbBus_awlen,
   output logic [ID_W-1:0]   PwbBus_awusrid,
   output logic              PwbBus_awuserap,
   output logic              PwbBus_wvalid,
   input  logic              BusPwb_wready,
   output logic [WORD_W-1:0] PwbBus_wdata,
   output logic              PwbBus_wlast,
   input  logic              BusPwb_bvalid,
   input  logic [ID_W-1:0]   BusPwb_bid,
   output logic              PwbBus_bready
);

   localparam logic [3:0] BEAT_LAST = 4'(BURST_BEATS - 1);

   pwb_state_e state_q, state_d;
   logic [3:0] beat_q, beat_d;

   // A response carrying another master's id is not ours; keep waiting.
   assign done     = (state_q == ST_B) && BusPwb_bvalid && (BusPwb_bid == WR_ID);
   assign beat_idx = beat_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_AW;
         ST_AW: begin
            if (BusPwb_awready) begin
               state_d = ST_W;
               beat_d  = 4'd0;
            end
         end
         ST_W: begin
            if (BusPwb_wready) begin
               if (beat_q == BEAT_LAST) state_d = ST_B;
               else                     beat_d  = beat_q + 4'd1;
            end
         end
         ST_B: if (done) state_d = start ? ST_AW : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      PwbBus_awlen    = AWLEN;
      PwbBus_awusrid  = WR_ID;
      PwbBus_awvalid  = (state_q == ST_AW);
      PwbBus_awaddr   = (state_q == ST_AW) ? req_addr : '0;
      PwbBus_awuserap = (state_q == ST_AW) && req_ap;
      PwbBus_wvalid   = (state_q == ST_W);
      PwbBus_wdata    = (state_q == ST_W) ? beat_data : '0;
      PwbBus_wlast    = (state_q == ST_W) && (beat_q == BEAT_LAST);
      PwbBus_bready   = (state_q == ST_B);
   end

endmodule

// File: rtl/pool_wr_ctrl.sv
// rtl/pool_wr_ctrl.sv - pooled pixel write-back: pixel buffer, address/pixel tracking, image done
module pool_wr_ctrl
   import pool_bus_pkg::*;
#(
   parameter int              channel_size = 64,
   parameter int              word_len     = 32,
   parameter logic [ID_W-1:0] wr_id        = 4'd1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           MpPwb_valid,
   input  logic [channel_size*word_len-1:0] MpPwb_data,
   output logic                           PwbMp_ready,
   input  logic                           PcPwb_initAddrEn,
   input  logic [ADDR_W-1:0]              PcPwb_initAddr,
   input  logic [11:0]                    PcPwb_pixCnt,
   output logic                           PwbPc_imgDone,
   output logic [ADDR_W-1:0]              PwbPc_imgEndAddr,
   output logic                           PwbBus_awvalid,
   input  logic                           BusPwb_awready,
   output logic [ADDR_W-1:0]              PwbBus_awaddr,
   output logic [3:0]                     PwbBus_awlen,
   output logic [ID_W-1:0]                PwbBus_awusrid,
   output logic                           PwbBus_awuserap,
   output logic                           PwbBus_wvalid,
   input  logic                           BusPwb_wready,
   output logic [word_len-1:0]            PwbBus_wdata,
   output logic                           PwbBus_wlast,
   input  logic                           BusPwb_bvalid,
   input  logic [ID_W-1:0]                BusPwb_bid,
   output logic                           PwbBus_bready
);

   localparam int                BURSTS     = channel_size / BURST_BEATS;
   localparam int                BIW        = (BURSTS > 1) ? $clog2(BURSTS) : 1;
   localparam logic [BIW-1:0]    LAST_BURST = BIW'(BURSTS - 1);
   localparam logic [ADDR_W-1:0] PIX_BYTES  = ADDR_W'(channel_size * BEAT_BYTES);
   localparam logic [ADDR_W-1:0] BST_BYTES  = ADDR_W'(BURST_BYTES);

   // ST_AW at this level means "pixel in flight"; the bridge owns AW/W/B detail.
   pwb_state_e                      state_q, state_d;
   logic [ADDR_W-1:0]               cur_addr_q, cur_addr_d;
   logic [11:0]                     pix_left_q, pix_left_d;
   logic [BIW-1:0]                  burst_idx_q, burst_idx_d;
   logic [channel_size*word_len-1:0] buf_q, buf_d;
   logic                            img_done_q, img_done_d;
   logic [ADDR_W-1:0]               img_end_q, img_end_d;

   logic                start, done, accept, init_ok, busy_done, pix_done;
   logic [3:0]          beat_idx;
   logic [BIW+3:0]      word_idx;
   logic [word_len-1:0] beat_data;
   logic [ADDR_W-1:0]   req_addr;

   assign accept    = MpPwb_valid && (state_q == ST_IDLE);
   assign init_ok   = PcPwb_initAddrEn && ((state_q == ST_UNINIT) || (state_q == ST_IDLE));
   assign busy_done = (state_q == ST_AW) && done;
   assign pix_done  = busy_done && (burst_idx_q == LAST_BURST);
   assign word_idx  = {burst_idx_q, beat_idx};
   assign beat_data = buf_q[int'(word_idx)*word_len +: word_len];
   assign req_addr  = cur_addr_q + ADDR_W'(burst_idx_q) * BST_BYTES;

   assign PwbPc_imgDone    = img_done_q;
   assign PwbPc_imgEndAddr = img_end_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_UNINIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_UNINIT: if (init_ok) state_d = ST_IDLE;
         ST_IDLE:   if (accept)  state_d = ST_AW;
         ST_AW:     if (pix_done) state_d = (pix_left_q == 12'd1) ? ST_UNINIT : ST_IDLE;
         default:   state_d = ST_UNINIT;
      endcase
   end

   always_comb begin
      PwbMp_ready = (state_q == ST_IDLE);
      start       = accept || (busy_done && (burst_idx_q != LAST_BURST));
   end

   always_comb begin
      cur_addr_d  = cur_addr_q;
      pix_left_d  = pix_left_q;
      burst_idx_d = burst_idx_q;
      buf_d       = buf_q;
      img_done_d  = 1'b0;
      img_end_d   = '0;
      if (init_ok) begin
         cur_addr_d  = PcPwb_initAddr;
         pix_left_d  = PcPwb_pixCnt;
         burst_idx_d = '0;
      end
      if (accept) buf_d = MpPwb_data;
      if (busy_done) begin
         if (burst_idx_q != LAST_BURST) begin
            burst_idx_d = burst_idx_q + BIW'(1);
         end else begin
            burst_idx_d = '0;
            cur_addr_d  = cur_addr_q + PIX_BYTES;
            pix_left_d  = pix_left_q - 12'd1;
            if (pix_left_q == 12'd1) begin
               img_done_d = 1'b1;
               img_end_d  = cur_addr_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_addr_q  <= '0;
         pix_left_q  <= '0;
         burst_idx_q <= '0;
         buf_q       <= '0;
         img_done_q  <= 1'b0;
         img_end_q   <= '0;
      end else begin
         cur_addr_q  <= cur_addr_d;
         pix_left_q  <= pix_left_d;
         burst_idx_q <= burst_idx_d;
         buf_q       <= buf_d;
         img_done_q  <= img_done_d;
         img_end_q   <= img_end_d;
      end
   end

   pool_wr_bridge #(
      .WORD_W (word_len),
      .WR_ID  (wr_id)
   ) u_bridge (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .req_addr        (req_addr),
      .req_ap          (burst_idx_q == LAST_BURST),
      .beat_idx        (beat_idx),
      .beat_data       (beat_data),
      .done            (done),
      .PwbBus_awvalid  (PwbBus_awvalid),
      .BusPwb_awready  (BusPwb_awready),
      .PwbBus_awaddr   (PwbBus_awaddr),
      .PwbBus_awlen    (PwbBus_awlen),
      .PwbBus_awusrid  (PwbBus_awusrid),
      .PwbBus_awuserap (PwbBus_awuserap),
      .PwbBus_wvalid   (PwbBus_wvalid),
      .BusPwb_wready   (BusPwb_wready),
      .PwbBus_wdata    (PwbBus_wdata),
      .PwbBus_wlast    (PwbBus_wlast),
      .BusPwb_bvalid   (BusPwb_bvalid),
      .BusPwb_bid      (BusPwb_bid),
      .PwbBus_bready   (PwbBus_bready)
   );

endmodule

// File: tb/tb_pool_wr_ctrl.sv
// tb/tb_pool_wr_ctrl.sv - directed self-checking bench for pool_wr_ctrl
module tb_pool_wr_ctrl;

   localparam int CH     = 64;
   localparam int BURSTS = CH / 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              MpPwb_valid;
   logic [CH*32-1:0]  MpPwb_data;
   logic              PwbMp_ready;
   logic              PcPwb_initAddrEn;
   logic [27:0]       PcPwb_initAddr;
   logic [11:0]       PcPwb_pixCnt;
   logic              PwbPc_imgDone;
   logic [27:0]       PwbPc_imgEndAddr;
   logic              PwbBus_awvalid, BusPwb_awready;
   logic [27:0]       PwbBus_awaddr;
   logic [3:0]        PwbBus_awlen, PwbBus_awusrid;
   logic              PwbBus_awuserap;
   logic              PwbBus_wvalid, BusPwb_wready;
   logic [31:0]       PwbBus_wdata;
   logic              PwbBus_wlast;
   logic              BusPwb_bvalid;
   logic [3:0]        BusPwb_bid;
   logic              PwbBus_bready;

   pool_wr_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .MpPwb_valid      (MpPwb_valid),
      .MpPwb_data       (MpPwb_data),
      .PwbMp_ready      (PwbMp_ready),
      .PcPwb_initAddrEn (PcPwb_initAddrEn),
      .PcPwb_initAddr   (PcPwb_initAddr),
      .PcPwb_pixCnt     (PcPwb_pixCnt),
      .PwbPc_imgDone    (PwbPc_imgDone),
      .PwbPc_imgEndAddr (PwbPc_imgEndAddr),
      .PwbBus_awvalid   (PwbBus_awvalid),
      .BusPwb_awready   (BusPwb_awready),
      .PwbBus_awaddr    (PwbBus_awaddr),
      .PwbBus_awlen     (PwbBus_awlen),
      .PwbBus_awusrid   (PwbBus_awusrid),
      .PwbBus_awuserap  (PwbBus_awuserap),
      .PwbBus_wvalid    (PwbBus_wvalid),
      .BusPwb_wready    (BusPwb_wready),
      .PwbBus_wdata     (PwbBus_wdata),
      .PwbBus_wlast     (PwbBus_wlast),
      .BusPwb_bvalid    (BusPwb_bvalid),
      .BusPwb_bid       (BusPwb_bid),
      .PwbBus_bready    (PwbBus_bready)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          aw_n, w_n, b_n, done_n;
   int          acc_cyc, done_cyc;
   int          tag;
   int          bad_bid_left = 0;
   bit          bad_prev = 0;
   bit          stall_en = 0;
   bit          aw_pend, w_pend;
   logic [29:0] aw_pend_val;
   logic [33:0] w_pend_val;
   logic [27:0] end_addr;
   logic [27:0] exp_base [4];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_word(input int t, input int p, input int k);
      return 32'((t << 16) | (p << 8) | k);
   endfunction

   // One cycle: drive the bus responder for the coming edge, then score what that edge will see.
   task automatic step();
      logic [27:0] ea;
      int          p, b;
      bit          bad_now;
      @(negedge clk);
      cyc++;
      bad_now        = 0;
      BusPwb_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      BusPwb_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      BusPwb_bid     = 4'd1;
      BusPwb_bvalid  = 1'b0;
      if (PwbBus_bready) begin
         if (bad_bid_left > 0) begin
            BusPwb_bvalid = 1'b1;
            BusPwb_bid    = 4'd2;
            bad_bid_left--;
            bad_now = 1;
         end else begin
            BusPwb_bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      if (bad_prev) chk("bad_bid_hold", PwbBus_bready, 1);
      bad_prev = bad_now;
      if (aw_pend) chk("aw_stable", {PwbBus_awvalid, PwbBus_awuserap, PwbBus_awaddr}, aw_pend_val);
      if (w_pend)  chk("w_stable", {PwbBus_wvalid, PwbBus_wlast, PwbBus_wdata}, w_pend_val);
      if (PwbBus_awvalid && BusPwb_awready) begin
         p  = aw_n / BURSTS;
         b  = aw_n % BURSTS;
         ea = exp_base[p % 4] + 28'(b * 64);
         chk("awaddr", PwbBus_awaddr, ea);
         chk("awuserap", PwbBus_awuserap, b == BURSTS - 1);
         chk("aw_after_b", aw_n, b_n);
         aw_n++;
      end
      aw_pend     = PwbBus_awvalid && !BusPwb_awready;
      aw_pend_val = {PwbBus_awvalid, PwbBus_awuserap, PwbBus_awaddr};
      if (PwbBus_wvalid && BusPwb_wready) begin
         chk("wdata", PwbBus_wdata, exp_word(tag, w_n / CH, w_n % CH));
         chk("wlast", PwbBus_wlast, (w_n % 16) == 15);
         chk("w_after_aw", (w_n / 16) < aw_n, 1);
         w_n++;
      end
      w_pend     = PwbBus_wvalid && !BusPwb_wready;
      w_pend_val = {PwbBus_wvalid, PwbBus_wlast, PwbBus_wdata};
      if (BusPwb_bvalid && PwbBus_bready && BusPwb_bid == 4'd1) b_n++;
      if (PwbPc_imgDone) begin
         done_n++;
         done_cyc = cyc;
         end_addr = PwbPc_imgEndAddr;
      end else begin
         chk("end_addr_idle", PwbPc_imgEndAddr, 0);
      end
   endtask

   task automatic clear_mon();
      aw_n = 0; w_n = 0; b_n = 0; done_n = 0;
      aw_pend = 0; w_pend = 0; end_addr = '0;
   endtask

   task automatic do_init(input logic [27:0] a, input logic [11:0] n);
      PcPwb_initAddrEn = 1'b1;
      PcPwb_initAddr   = a;
      PcPwb_pixCnt     = n;
      step();
      PcPwb_initAddrEn = 1'b0;
   endtask

   task automatic send_pix(input int p);
      int n = 0;
      for (int k = 0; k < CH; k++) MpPwb_data[k*32 +: 32] = exp_word(tag, p, k);
      MpPwb_valid = 1'b1;
      while (!PwbMp_ready && n < 2000) begin
         step();
         n++;
      end
      chk("ready_seen", PwbMp_ready, 1);
      acc_cyc = cyc;
      step();
      MpPwb_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_n == 0 && n < budget) begin
         step();
         n++;
      end
      chk("done_seen", done_n, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      MpPwb_valid = 1'b0; MpPwb_data = '0;
      PcPwb_initAddrEn = 1'b0; PcPwb_initAddr = '0; PcPwb_pixCnt = '0;
      BusPwb_awready = 1'b0; BusPwb_wready = 1'b0; BusPwb_bvalid = 1'b0; BusPwb_bid = 4'd1;
      tag = 0;
      foreach (exp_base[i]) exp_base[i] = '0;
      clear_mon();
      repeat (3) step();
      chk("rst_ready", PwbMp_ready, 0);
      chk("rst_valids", {PwbBus_awvalid, PwbBus_wvalid, PwbBus_bready, PwbPc_imgDone}, 0);
      chk("rst_awlen", PwbBus_awlen, 15);
      chk("rst_awusrid", PwbBus_awusrid, 1);
      chk("rst_awaddr", PwbBus_awaddr, 0);
      rst_n = 1'b1;
      step();

      // input held before any init is never taken
      MpPwb_valid = 1'b1;
      repeat (5) begin
         step();
         chk("uninit_ready", PwbMp_ready, 0);
      end
      MpPwb_valid = 1'b0;
      chk("uninit_no_aw", aw_n, 0);

      // single pixel, no backpressure
      clear_mon();
      exp_base[0] = 28'h0001000;
      tag = 0;
      do_init(28'h0001000, 12'd1);
      chk("init_ready", PwbMp_ready, 1);
      send_pix(0);
      chk("aw_next_cycle", PwbBus_awvalid, 1);
      wait_done(500);
      chk("latency", done_cyc - acc_cyc, 73);
      chk("end_addr1", end_addr, 28'h0001000);
      chk("cnt1", {8'(aw_n), 8'(w_n), 8'(b_n)}, {8'd4, 8'd64, 8'd4});
      step();
      chk("done_pulse", PwbPc_imgDone, 0);
      chk("back_uninit", PwbMp_ready, 0);

      // three pixels with random stalls on every channel
      clear_mon();
      exp_base[0] = 28'h0001000; exp_base[1] = 28'h0001100; exp_base[2] = 28'h0001200;
      tag = 1;
      do_init(28'h0001000, 12'd3);
      stall_en = 1;
      for (int p = 0; p < 3; p++) send_pix(p);
      wait_done(3000);
      repeat (5) step();
      stall_en = 0;
      chk("stall_done_once", done_n, 1);
      chk("stall_end_addr", end_addr, 28'h0001200);
      chk("stall_cnt", {8'(aw_n), 8'(w_n), 8'(b_n)}, {8'd12, 8'd192, 8'd12});

      // init pulsed mid-W is ignored; wrong bid is ignored
      clear_mon();
      exp_base[0] = 28'h0002000;
      tag = 2;
      do_init(28'h0002000, 12'd1);
      send_pix(0);
      n = 0;
      while (!PwbBus_wvalid && n < 50) begin step(); n++; end
      chk("w_reached", PwbBus_wvalid, 1);
      do_init(28'h0ABC000, 12'd5);
      bad_bid_left = 3;
      wait_done(500);
      chk("badid_end_addr", end_addr, 28'h0002000);
      chk("badid_cnt", {8'(aw_n), 8'(w_n), 8'(b_n)}, {8'd4, 8'd64, 8'd4});
      step();
      chk("badid_uninit", PwbMp_ready, 0);

      // address wrap at 2^28
      clear_mon();
      exp_base[0] = 28'hFFFFF00; exp_base[1] = 28'h0000000;
      tag = 3;
      do_init(28'hFFFFF00, 12'd2);
      send_pix(0);
      send_pix(1);
      wait_done(500);
      chk("wrap_end_addr", end_addr, 28'h0000000);
      chk("wrap_cnt", {8'(aw_n), 8'(w_n)}, {8'd8, 8'd128});

      // reset in the middle of a burst, then a clean pixel
      clear_mon();
      exp_base[0] = 28'h0003000;
      tag = 4;
      do_init(28'h0003000, 12'd1);
      send_pix(0);
      n = 0;
      while (!(PwbBus_wvalid && w_n == 8) && n < 50) begin step(); n++; end
      chk("beat7_reached", w_n, 8);
      rst_n = 1'b0;
      step();
      chk("abort_valids", {PwbBus_awvalid, PwbBus_wvalid, PwbBus_bready, PwbMp_ready}, 0);
      rst_n = 1'b1;
      step();
      chk("abort_uninit", PwbMp_ready, 0);
      clear_mon();
      exp_base[0] = 28'h0004000;
      tag = 5;
      do_init(28'h0004000, 12'd1);
      send_pix(0);
      wait_done(500);
      chk("reinit_end_addr", end_addr, 28'h0004000);
      chk("reinit_cnt", {8'(aw_n), 8'(w_n), 8'(b_n)}, {8'd4, 8'd64, 8'd4});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
